spike_rate_encoder: RTL and testbench

Rate-codes a vector of 8-bit input intensities (pixels) into Bernoulli spike trains that drive the pre_spike inputs of the synapse array. A sample is accepted through a valid/ready handshake and then encoded over a fixed window of WINDOW_LEN timesteps. Per channel, a spike fires on a step when an LFSR draw is below the channel's intensity. The block sits directly upstream of the synapse stage, with one pre_spike bit per synapse row.

---
 rtl/neuron_pkg.sv | 31 +++
 rtl/spike_lfsr.sv | 29 ++
 rtl/spike_rate_encoder.sv | 135 +++++++++++++
 tb/tb_spike_rate_encoder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types, constants and LFSR helpers for the spike rate encoder.
package neuron_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int DEFAULT_WINDOW_LEN = 16;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    DONE
  } enc_state_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] base,
                                                  input int unsigned       idx);
    logic [31:0]       prod;
    logic [LFSR_W-1:0] s;
    prod = idx * 32'h0000_1F35;
    s    = base ^ prod[LFSR_W-1:0];
    lfsr_seed = (s == '0) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/spike_lfsr.sv
// Per-channel 16-bit Galois LFSR; draw_o is the low byte of the value the
// register takes on the next advance, so the compare and the step share an edge.
module spike_lfsr
  import neuron_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   advance_i,
  output pixel_t draw_o
);

  logic [LFSR_W-1:0] state_q, state_d, next_w;

  assign next_w = lfsr_next(state_q);
  assign draw_o = next_w[7:0];

  always_comb begin
    state_d = state_q;
    if (advance_i) state_d = next_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Bernoulli rate encoder: latches one intensity vector and emits WINDOW_LEN
// steps of spikes. Optional per-channel spike counters: define SPIKE_COUNT_EN.
module spike_rate_encoder
  import neuron_pkg::*;
#(
  parameter int                NUM_INPUTS = 4,
  parameter int                PIXEL_W    = 8,
  parameter int                WINDOW_LEN = DEFAULT_WINDOW_LEN,
  parameter logic [LFSR_W-1:0] SEED_BASE  = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pixel_valid,
  output logic                          pixel_ready,
  input  logic [NUM_INPUTS*PIXEL_W-1:0] pixel_data,
  input  logic                          step_en,
  output logic [NUM_INPUTS-1:0]         pre_spike,
  output logic                          window_active,
  output logic                          window_done
`ifdef SPIKE_COUNT_EN
  ,
  output logic [NUM_INPUTS*8-1:0]       spike_count
`endif
);

  localparam int CNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WINDOW_LEN - 1);

  enc_state_t                    state_q, state_d;
  logic [CNT_W-1:0]              step_cnt_q, step_cnt_d;
  logic [NUM_INPUTS*PIXEL_W-1:0] pix_q, pix_d;
  logic [NUM_INPUTS-1:0]         spike_q, spike_d;
  logic [NUM_INPUTS-1:0]         hit_w;
  logic                          accept, step, last_step;

  assign accept    = pixel_valid & pixel_ready;
  assign step      = (state_q == ENCODE) & step_en;
  assign last_step = step & (step_cnt_q == LAST_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ENCODE;
      ENCODE:  if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pixel_ready   = 1'b0;
    window_active = 1'b0;
    window_done   = 1'b0;
    case (state_q)
      IDLE:    pixel_ready   = 1'b1;
      ENCODE:  window_active = 1'b1;
      DONE:    window_done   = 1'b1;
      default: pixel_ready   = 1'b0;
    endcase
  end

  // Stage: one LFSR draw per channel, compared against the latched intensity.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    pixel_t               draw;
    logic [PIXEL_W-1:0]   pix;

    spike_lfsr #(
      .SEED(lfsr_seed(SEED_BASE, i))
    ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance_i(step),
      .draw_o   (draw)
    );

    assign pix      = pix_q[i*PIXEL_W +: PIXEL_W];
    assign hit_w[i] = (pix == {PIXEL_W{1'b1}}) | (draw < pix);
  end

  always_comb begin
    pix_d      = pix_q;
    step_cnt_d = step_cnt_q;
    spike_d    = step ? hit_w : '0;
    if (accept) begin
      pix_d      = pixel_data;
      step_cnt_d = '0;
    end else if (step) begin
      step_cnt_d = step_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q      <= '0;
      step_cnt_q <= '0;
      spike_q    <= '0;
    end else begin
      pix_q      <= pix_d;
      step_cnt_q <= step_cnt_d;
      spike_q    <= spike_d;
    end
  end

  assign pre_spike = spike_q;

`ifdef SPIKE_COUNT_EN
  logic [NUM_INPUTS*8-1:0] cnt_q, cnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage: counters move on the same edge that registers the spike.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (accept)          cnt_d[i*8 +: 8] = 8'd0;
      else if (spike_d[i]) cnt_d[i*8 +: 8] = sat_inc8(cnt_q[i*8 +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign spike_count = cnt_q;
`endif

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Randomised self-checking bench for spike_rate_encoder with a reference LFSR model.
module tb_spike_rate_encoder;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        step_en = 1'b0;
  logic [31:0] pixel_data = '0;
  logic        pixel_ready, window_active, window_done;
  logic [3:0]  pre_spike;
`ifdef SPIKE_COUNT_EN
  logic [31:0] spike_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned m_lfsr [N];

  always #5 clk = ~clk;

  spike_rate_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .pixel_data   (pixel_data),
    .step_en      (step_en),
    .pre_spike    (pre_spike),
    .window_active(window_active),
    .window_done  (window_done)
`ifdef SPIKE_COUNT_EN
    ,
    .spike_count  (spike_count)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reseed();
    for (int i = 0; i < N; i++) begin
      logic [31:0] p;
      logic [15:0] s;
      p = i * 32'h1F35;
      s = 16'hACE1 ^ p[15:0];
      if (s == 16'h0000) s = 16'h0001;
      m_lfsr[i] = s;
    end
  endtask

  // One encoding step: polynomial division step on each channel, then Bernoulli decision.
  task automatic model_step(input logic [31:0] pix, output logic [3:0] sp);
    for (int ch = 0; ch < N; ch++) begin
      int unsigned s, p;
      s = m_lfsr[ch];
      if (s % 2 == 1) s = (s / 2) ^ 32'h0000_B400;
      else            s = s / 2;
      m_lfsr[ch] = s;
      p = (pix >> (8 * ch)) & 32'hFF;
      sp[ch] = (p == 255) || ((s % 256) < p);
    end
  endtask

  task automatic do_reset();
    pixel_valid = 1'b0;
    step_en     = 1'b0;
    #2 rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reseed();
  endtask

  task automatic do_accept(input logic [31:0] pix);
    int k;
    pixel_data  = pix;
    pixel_valid = 1'b1;
    k = 0;
    while (pixel_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_wait: pixel_ready=%b after %0d cycles, need 1", pixel_ready, k);
    end
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step_en = c[0];
      n_checks++;
      if (pixel_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready: got %b need 1", pixel_ready);
      end
      n_checks++;
      if (pre_spike !== 4'h0 || window_active !== 1'b0 || window_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_outs: spike=%h act=%b done=%b need 0/0/0",
                 pre_spike, window_active, window_done);
      end
      tick();
    end
    step_en = 1'b0;
  endtask

  task automatic test_fixed();
    logic [31:0] pix;
    logic [3:0]  sp;
    int          cd [N];
    int          cm [N];
    pix = 32'hFF80_0100;
    for (int i = 0; i < N; i++) begin cd[i] = 0; cm[i] = 0; end
    step_en = 1'b1;
    do_accept(pix);
    n_checks++;
    if (window_active !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_active: got %b need 1", window_active);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      model_step(pix, sp);
      for (int i = 0; i < N; i++) begin cd[i] += pre_spike[i]; cm[i] += sp[i]; end
      n_checks++;
      if (pre_spike !== sp) begin
        n_fail++;
        $display("FAIL fixed_spike step %0d: got %h need %h", k, pre_spike, sp);
      end
      n_checks++;
      if (window_done !== (k == 15)) begin
        n_fail++;
        $display("FAIL fixed_done_timing step %0d: got %b need %b", k, window_done, (k == 15));
      end
    end
    n_checks++;
    if (cd[3] !== 16 || cd[0] !== 0) begin
      n_fail++;
      $display("FAIL fixed_extremes: ch3=%0d ch0=%0d need 16/0", cd[3], cd[0]);
    end
    n_checks++;
    if (cd[1] !== cm[1] || cd[2] !== cm[2]) begin
      n_fail++;
      $display("FAIL fixed_counts: ch1=%0d ch2=%0d need %0d/%0d", cd[1], cd[2], cm[1], cm[2]);
    end
    tick();
    n_checks++;
    if (pre_spike !== 4'h0 || pixel_ready !== 1'b1 || window_done !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_after: spike=%h rdy=%b done=%b need 0/1/0",
               pre_spike, pixel_ready, window_done);
    end
    step_en = 1'b0;
  endtask

  task automatic test_handshake();
    logic [31:0] pa, pb;
    logic [3:0]  sp;
    pa = $urandom;
    pb = $urandom;
    step_en = 1'b1;
    do_accept(pa);
    pixel_valid = 1'b1;
    pixel_data  = pb;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (pixel_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hs_ready_encode step %0d: got %b need 0", k, pixel_ready);
      end
      tick();
      model_step(pa, sp);
      n_checks++;
      if (pre_spike !== sp) begin
        n_fail++;
        $display("FAIL hs_latched_data step %0d: got %h need %h", k, pre_spike, sp);
      end
    end
    n_checks++;
    if (window_done !== 1'b1 || pixel_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_done_state: done=%b rdy=%b need 1/0", window_done, pixel_ready);
    end
    tick();
    n_checks++;
    if (pixel_ready !== 1'b1 || window_active !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_idle_after_done: rdy=%b act=%b need 1/0", pixel_ready, window_active);
    end
    tick();
    pixel_valid = 1'b0;
    n_checks++;
    if (window_active !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_second_accept: act=%b need 1", window_active);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      model_step(pb, sp);
      n_checks++;
      if (pre_spike !== sp || window_done !== (k == 15)) begin
        n_fail++;
        $display("FAIL hs_second_window step %0d: spike=%h done=%b need %h/%b",
                 k, pre_spike, window_done, sp, (k == 15));
      end
    end
    tick();
    step_en = 1'b0;
  endtask

  task automatic test_toggle();
    logic [3:0] sp;
    step_en = 1'b0;
    do_accept(32'hFFFF_FFFF);
    for (int c = 0; c < 32; c++) begin
      step_en = (c % 2 == 0);
      tick();
      if (c % 2 == 0) model_step(32'hFFFF_FFFF, sp);
      else            sp = 4'h0;
      n_checks++;
      if (pre_spike !== sp) begin
        n_fail++;
        $display("FAIL toggle_spike cycle %0d: got %h need %h", c, pre_spike, sp);
      end
      n_checks++;
      if (window_done !== (c == 30)) begin
        n_fail++;
        $display("FAIL toggle_done cycle %0d: got %b need %b", c, window_done, (c == 30));
      end
    end
    n_checks++;
    if (pixel_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL toggle_end_ready: got %b need 1", pixel_ready);
    end
    step_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] pix;
    logic [3:0]  sp;
    logic [3:0]  pat [16];
    pix = 32'h40C0_2090 ^ ($urandom & 32'h1F1F_1F1F);
    do_reset();
    step_en = 1'b1;
    do_accept(pix);
    for (int k = 0; k < 16; k++) begin
      tick();
      model_step(pix, sp);
      pat[k] = pre_spike;
      n_checks++;
      if (pre_spike !== sp) begin
        n_fail++;
        $display("FAIL rmid_first step %0d: got %h need %h", k, pre_spike, sp);
      end
    end
    tick();
    do_accept(pix);
    for (int k = 0; k < 7; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (pre_spike !== 4'h0 || window_active !== 1'b0 || pixel_ready !== 1'b1 ||
        window_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: spike=%h act=%b rdy=%b done=%b need 0/0/1/0",
               pre_spike, window_active, pixel_ready, window_done);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (window_done !== 1'b0 || window_active !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_held: done=%b act=%b need 0/0", window_done, window_active);
      end
    end
    rst_n = 1'b1;
    model_reseed();
    tick();
    n_checks++;
    if (window_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_no_done: got %b need 0", window_done);
    end
    do_accept(pix);
    for (int k = 0; k < 16; k++) begin
      tick();
      model_step(pix, sp);
      n_checks++;
      if (pre_spike !== pat[k]) begin
        n_fail++;
        $display("FAIL rmid_reseed step %0d: got %h need %h", k, pre_spike, pat[k]);
      end
    end
    tick();
    step_en = 1'b0;
  endtask

  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      logic [31:0] pix;
      logic [3:0]  sp;
      int          steps, cyc;
      logic        st;
      for (int ch = 0; ch < N; ch++) begin
        int unsigned sel;
        sel = $urandom_range(0, 3);
        pix[8*ch +: 8] = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      end
      step_en = $urandom_range(0, 1);
      do_accept(pix);
      steps = 0;
      cyc   = 0;
      while (steps < 16 && cyc < 400) begin
        st = $urandom_range(0, 1);
        step_en = st;
        tick();
        cyc++;
        if (st) begin
          model_step(pix, sp);
          steps++;
        end else begin
          sp = 4'h0;
        end
        n_checks++;
        if (pre_spike !== sp) begin
          n_fail++;
          $display("FAIL rand_spike win %0d cyc %0d: got %h need %h", w, cyc, pre_spike, sp);
        end
        n_checks++;
        if (window_done !== (steps == 16) || window_active !== (steps < 16)) begin
          n_fail++;
          $display("FAIL rand_ctrl win %0d cyc %0d: done=%b act=%b need %b/%b",
                   w, cyc, window_done, window_active, (steps == 16), (steps < 16));
        end
      end
      if (steps < 16) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_budget win %0d: %0d steps seen, need 16", w, steps);
      end
      step_en = $urandom_range(0, 1);
      tick();
    end
    step_en = 1'b0;
  endtask

`ifdef SPIKE_COUNT_EN
  task automatic test_spike_count();
    logic [31:0] pix;
    logic [3:0]  sp;
    int          c2;
    pix = 32'h0080_FFFF;
    c2  = 0;
    step_en = 1'b1;
    do_accept(pix);
    for (int k = 0; k < 16; k++) begin
      tick();
      model_step(pix, sp);
      c2 += sp[2];
    end
    n_checks++;
    if (window_done !== 1'b1 || spike_count[7:0] !== 8'd16 || spike_count[15:8] !== 8'd16 ||
        spike_count[31:24] !== 8'd0 || spike_count[23:16] !== 8'(c2)) begin
      n_fail++;
      $display("FAIL count_window: done=%b counts=%h need ch0/1=16 ch2=%0d ch3=0",
               window_done, spike_count, c2);
    end
    step_en = 1'b0;
    do_accept(32'h1234_5678);
    n_checks++;
    if (spike_count !== 32'h0) begin
      n_fail++;
      $display("FAIL count_clear: got %h need 0", spike_count);
    end
    step_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      model_step(32'h1234_5678, sp);
    end
    tick();
    step_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_handshake();
    test_toggle();
    test_reset_mid();
    test_random();
`ifdef SPIKE_COUNT_EN
    test_spike_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
